// File: rtl/text_packer_pkg.sv
// Shared types and helpers for the byte-serial to packed-string converter.
package text_packer_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    DROP = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic [7:0] TERM_DEFAULT = 8'h00;

  function automatic int len_w(input int bytes);
    return $clog2(bytes + 1);
  endfunction

endpackage

// File: rtl/text_shift_reg.sv
// Byte shifter that packs bytes MSB-first into a wide register and counts them.
// Shift takes effect on the next edge; shifts are ignored once full so the count never wraps.
module text_shift_reg
  import text_packer_pkg::*;
#(
  parameter int WIDTH_BYTES = 64,
  parameter int LEN_W       = len_w(WIDTH_BYTES)
) (
  input  logic                     clk,
  input  logic                     reset_l,
  input  logic                     shift,
  input  logic [7:0]               data,
  input  logic                     clear,
  output logic [8*WIDTH_BYTES-1:0] text_out,
  output logic [LEN_W-1:0]         text_len,
  output logic                     full
);

  localparam int TW = 8 * WIDTH_BYTES;

  assign full = (text_len == LEN_W'(WIDTH_BYTES));

  always_ff @(posedge clk) begin
    if (!reset_l || clear) begin
      text_out <= '0;
      text_len <= '0;
    end else if (shift && !full) begin
      // Shift-then-OR keeps the expression legal even for a one-byte register.
      text_out <= (text_out << 8) | TW'(data);
      text_len <= text_len + LEN_W'(1);
    end
  end

endmodule

// File: rtl/text_packer.sv
// Accepts ASCII bytes, commits the packed string on TERM and holds it until text_ack.
// One byte per cycle while filling; in_ready is low for the whole HOLD state.
module text_packer
  import text_packer_pkg::*;
#(
  parameter int         WIDTH_BYTES = 64,
  parameter logic [7:0] TERM        = TERM_DEFAULT
) (
  input  logic                             clk,
  input  logic                             reset_l,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [7:0]                       in_data,
  input  logic                             text_ack,
  output logic                             text_valid,
  output logic [8*WIDTH_BYTES-1:0]         text_out,
  output logic [len_w(WIDTH_BYTES)-1:0]    text_len,
  output logic                             overflow
);

  localparam int LW = len_w(WIDTH_BYTES);

  state_e state;
  logic   full;
  logic   accept;
  logic   is_term;
  logic   shift;
  logic   clear;

  assign in_ready = (state != HOLD);
  assign accept   = in_valid && in_ready;
  assign is_term  = (in_data == TERM);
  assign shift    = accept && (state == FILL) && !is_term && !full;
  assign clear    = (state == HOLD) && text_ack;

  text_shift_reg #(
    .WIDTH_BYTES (WIDTH_BYTES),
    .LEN_W       (LW)
  ) u_shift (
    .clk      (clk),
    .reset_l  (reset_l),
    .shift    (shift),
    .data     (in_data),
    .clear    (clear),
    .text_out (text_out),
    .text_len (text_len),
    .full     (full)
  );

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state      <= FILL;
      text_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (accept && is_term) begin
            state      <= HOLD;
            text_valid <= 1'b1;
          end else if (accept && full) begin
            state    <= DROP;
            overflow <= 1'b1;
          end
        end
        DROP: begin
          // Overflow stays set so the consumer sees the truncation at commit.
          if (accept && is_term) begin
            state      <= HOLD;
            text_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (text_ack) begin
            state      <= FILL;
            text_valid <= 1'b0;
            overflow   <= 1'b0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_text_packer.sv
// Drives one byte stream into 64-byte and 4-byte packers; a scoreboard checks each commit.
module tb_text_packer;

  logic         clk = 1'b0;
  logic         reset_l = 1'b0;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         text_ack = 1'b0;

  logic         rdy64, valid64, ovf64;
  logic [511:0] out64;
  logic [6:0]   len64;
  logic         rdy4, valid4, ovf4;
  logic [31:0]  out4;
  logic [2:0]   len4;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [511:0] txt;
    int           len;
    logic         ovf;
  } exp_t;

  exp_t q64[$];
  exp_t q4[$];

  logic [511:0] m64;
  int           l64;
  logic         o64;
  logic [31:0]  m4;
  int           l4;
  logic         o4;

  always #5 clk = ~clk;

  text_packer #(.WIDTH_BYTES(64)) dut64 (
    .clk(clk), .reset_l(reset_l), .in_valid(in_valid), .in_ready(rdy64),
    .in_data(in_data), .text_ack(text_ack), .text_valid(valid64),
    .text_out(out64), .text_len(len64), .overflow(ovf64)
  );

  text_packer #(.WIDTH_BYTES(4)) dut4 (
    .clk(clk), .reset_l(reset_l), .in_valid(in_valid), .in_ready(rdy4),
    .in_data(in_data), .text_ack(text_ack), .text_valid(valid4),
    .text_out(out4), .text_len(len4), .overflow(ovf4)
  );

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m64 = '0; l64 = 0; o64 = 1'b0;
    m4  = '0; l4  = 0; o4  = 1'b0;
  endtask

  // Reference behaviour for an accepted byte; TERM pushes the expected commit.
  task automatic model_accept(input logic [7:0] b);
    exp_t e;
    if (b == 8'h00) begin
      e.txt = m64; e.len = l64; e.ovf = o64; q64.push_back(e);
      e.txt = {480'd0, m4}; e.len = l4; e.ovf = o4; q4.push_back(e);
      model_clear();
    end else begin
      if (l64 < 64) begin m64 = {m64[503:0], b}; l64++; end else o64 = 1'b1;
      if (l4 < 4) begin m4 = {m4[23:0], b}; l4++; end else o4 = 1'b1;
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_rdy"}, {510'd0, rdy64, rdy4}, 512'd3);
    chk({tag, "_valid"}, {510'd0, valid64, valid4}, 512'd0);
    chk({tag, "_ovf"}, {510'd0, ovf64, ovf4}, 512'd0);
    chk({tag, "_len64"}, 512'(len64), 512'd0);
    chk({tag, "_len4"}, 512'(len4), 512'd0);
    chk({tag, "_out64"}, out64, 512'd0);
    chk({tag, "_out4"}, 512'(out4), 512'd0);
  endtask

  // Called at posedge+1; returns at posedge+1 after the byte is accepted.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    while (!(rdy64 && rdy4) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 512'(n < 50), 512'd1);
    @(posedge clk);
    if (n < 50) model_accept(b);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_string(input string s, input int max_gap);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i]);
      repeat ($urandom_range(max_gap, 0)) begin
        @(posedge clk);
        #1;
      end
    end
    send_byte(8'h00);
    chk("commit_valid", {510'd0, valid64, valid4}, 512'd3);
    chk("commit_rdy", {510'd0, rdy64, rdy4}, 512'd0);
  endtask

  task automatic do_ack(input int delay);
    repeat (delay) begin
      @(posedge clk);
      #1;
    end
    text_ack = 1'b1;
    @(posedge clk);
    #1 text_ack = 1'b0;
    check_idle("ack");
  endtask

  // Compare the held string once per commit, on the first cycle text_valid is seen.
  logic prev64 = 1'b0;
  logic prev4 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (valid64 && !prev64) begin
      chk("sb64_nonempty", 512'(q64.size() > 0), 512'd1);
      if (q64.size() > 0) begin
        e = q64.pop_front();
        chk("sb64_text", out64, e.txt);
        chk("sb64_len", 512'(len64), 512'(e.len));
        chk("sb64_ovf", 512'(ovf64), 512'(e.ovf));
      end
    end
    if (valid4 && !prev4) begin
      chk("sb4_nonempty", 512'(q4.size() > 0), 512'd1);
      if (q4.size() > 0) begin
        e = q4.pop_front();
        chk("sb4_text", 512'(out4), e.txt);
        chk("sb4_len", 512'(len4), 512'(e.len));
        chk("sb4_ovf", 512'(ovf4), 512'(e.ovf));
      end
    end
    prev64 = valid64;
    prev4  = valid4;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    string s;
    model_clear();
    repeat (3) @(posedge clk);
    #1 reset_l = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_idle("reset");

    send_string("Hf", 0);
    chk("hf_out64", out64, 512'h4866);
    chk("hf_len64", 512'(len64), 512'd2);
    do_ack(1);

    send_string("Long64b", 0);
    chk("long_out4", 512'(out4), 512'h4C6F6E67);
    chk("long_len4", 512'(len4), 512'd4);
    chk("long_ovf", {510'd0, ovf64, ovf4}, 512'd1);
    do_ack(0);

    send_string("", 0);
    chk("empty_len64", 512'(len64), 512'd0);
    chk("empty_out64", out64, 512'd0);
    do_ack(2);

    // Byte presented together with the ack must wait one more edge.
    send_string("Z", 0);
    in_valid = 1'b1;
    in_data  = 8'h41;
    text_ack = 1'b1;
    @(posedge clk);
    #1 text_ack = 1'b0;
    chk("hold_a_not_taken_len", 512'(len64), 512'd0);
    chk("hold_a_rdy", {510'd0, rdy64, rdy4}, 512'd3);
    chk("hold_a_valid", {510'd0, valid64, valid4}, 512'd0);
    @(posedge clk);
    model_accept(8'h41);
    #1 in_valid = 1'b0;
    chk("hold_a_out64", out64, 512'h41);
    chk("hold_a_len4", 512'(len4), 512'd1);
    send_string("", 0);
    do_ack(0);

    // Ack outside HOLD has no effect; reset mid-string discards everything.
    send_byte("T");
    send_byte("r");
    text_ack = 1'b1;
    @(posedge clk);
    #1 text_ack = 1'b0;
    chk("ack_in_fill_len", 512'(len64), 512'd2);
    chk("ack_in_fill_rdy", {510'd0, rdy64, rdy4}, 512'd3);
    reset_l = 1'b0;
    @(posedge clk);
    #1 reset_l = 1'b1;
    model_clear();
    check_idle("midreset");
    send_string("Tree", 0);
    chk("tree_out4", 512'(out4), 512'h54726565);
    chk("tree_out64", out64, 512'h54726565);
    chk("tree_len4", 512'(len4), 512'd4);
    chk("tree_ovf", {510'd0, ovf64, ovf4}, 512'd0);
    do_ack(1);

    // Reset while holding a committed string drops text_valid at once.
    send_string("ab", 0);
    reset_l = 1'b0;
    @(posedge clk);
    #1 reset_l = 1'b1;
    model_clear();
    check_idle("holdreset");

    for (int k = 0; k < 12; k++) begin
      s = "";
      for (int j = 0; j < int'($urandom_range(9, 0)); j++)
        s = {s, string'(8'($urandom_range(126, 32)))};
      send_string(s, 2);
      do_ack($urandom_range(3, 0));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb64_drained", 512'(q64.size()), 512'd0);
    chk("sb4_drained", 512'(q4.size()), 512'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
